// File: rtl/fact_pkg.sv
// fact_pkg: shared types and constants for the factorial job controller.
//   state_e   : controller FSM state (2 bits, same width as the engine's CS)
//   N_W_DEF   : default operand width
//   RES_W_DEF : default result width
//   MAX_N     : largest n whose factorial fits in 32 bits
package fact_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

    localparam int N_W_DEF   = 4;
    localparam int RES_W_DEF = 32;
    localparam int MAX_N     = 12;

endpackage

// File: rtl/fact_req_fifo.sv
// fact_req_fifo: synchronous request FIFO holding pending operands.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   push, push_data : write request and operand (ignored when full)
//   pop             : read request (ignored when empty)
//   full, empty     : occupancy status
//   head            : oldest entry; a pushed entry appears here the next cycle
module fact_req_fifo #(
    parameter int DEPTH = 4,
    parameter int N_W   = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  logic [N_W-1:0] push_data,
    input  logic           pop,
    output logic           full,
    output logic           empty,
    output logic [N_W-1:0] head
);

    localparam int           AW      = $clog2(DEPTH);
    localparam logic [AW:0]  DEPTH_C = (AW+1)'(DEPTH);

    logic [N_W-1:0] mem_q [DEPTH];
    logic [N_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           do_push, do_pop;

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // Simultaneous push and pop leave the count unchanged.
        count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: only entries below count are ever read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fact_job_ctrl.sv
// fact_job_ctrl: sequences factorial jobs onto the `fact` engine.
// Requests are queued in fact_req_fifo, launched one at a time with a one-cycle
// fact_go pulse, and each engine Done is returned as an in-order response.
// Ports:
//   req_valid/req_ready/req_n          : request channel
//   fact_go/fact_in                    : engine launch and operand
//   fact_done/fact_error/fact_result   : engine completion
//   rsp_valid/rsp_ready/rsp_n/rsp_result/rsp_error : response channel
//   busy                               : FSM active or requests pending
//   dbg_state                          : current FSM state
//   timeout_flag                       : response was forced by WAIT timeout
// Handshakes: a transfer happens on a rising edge where valid && ready; the
// sender keeps valid and its data stable until that edge.
// Build option: FACT_TIMEOUT_EN adds the WAIT timeout counter, the
// TIMEOUT_CYCLES parameter and the timeout_flag port.
module fact_job_ctrl
    import fact_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int N_W   = N_W_DEF,
    parameter int RES_W = RES_W_DEF
`ifdef FACT_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [N_W-1:0]   req_n,
    output logic             fact_go,
    output logic [N_W-1:0]   fact_in,
    input  logic             fact_done,
    input  logic             fact_error,
    input  logic [RES_W-1:0] fact_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [N_W-1:0]   rsp_n,
    output logic [RES_W-1:0] rsp_result,
    output logic             rsp_error,
    output logic             busy,
    output state_e           dbg_state
`ifdef FACT_TIMEOUT_EN
    ,
    output logic             timeout_flag
`endif
);

    state_e           state_q, state_d;
    logic [N_W-1:0]   op_q, op_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [N_W-1:0]   rsp_n_q, rsp_n_d;
    logic [RES_W-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_error_q, rsp_error_d;

    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [N_W-1:0]   fifo_head;

`ifdef FACT_TIMEOUT_EN
    localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);
    logic [CW-1:0] to_cnt_q, to_cnt_d;
    logic          timeout_flag_q, timeout_flag_d;
`endif

    assign req_ready = !fifo_full;
    assign fifo_push = req_valid && req_ready;

    fact_req_fifo #(
        .DEPTH (DEPTH),
        .N_W   (N_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (req_n),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_n_d      = rsp_n_q;
        rsp_result_d = rsp_result_q;
        rsp_error_d  = rsp_error_q;
        fifo_pop     = 1'b0;
        fact_go      = 1'b0;
`ifdef FACT_TIMEOUT_EN
        to_cnt_d       = to_cnt_q;
        timeout_flag_d = timeout_flag_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    op_d     = fifo_head;
                    state_d  = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                fact_go = 1'b1;
                state_d = ST_WAIT;
`ifdef FACT_TIMEOUT_EN
                to_cnt_d = '0;
`endif
            end
            ST_WAIT: begin
`ifdef FACT_TIMEOUT_EN
                to_cnt_d = to_cnt_q + 1'b1;
`endif
                // Done takes priority over a timeout in the same cycle.
                if (fact_done) begin
                    rsp_valid_d  = 1'b1;
                    rsp_n_d      = op_q;
                    rsp_error_d  = fact_error;
                    rsp_result_d = fact_error ? '0 : fact_result;
                    state_d      = ST_HOLD;
`ifdef FACT_TIMEOUT_EN
                    timeout_flag_d = 1'b0;
                end else if (to_cnt_q == TO_LIMIT) begin
                    rsp_valid_d    = 1'b1;
                    rsp_n_d        = op_q;
                    rsp_error_d    = 1'b1;
                    rsp_result_d   = '0;
                    timeout_flag_d = 1'b1;
                    state_d        = ST_HOLD;
`endif
                end
            end
            ST_HOLD: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
`ifdef FACT_TIMEOUT_EN
                    timeout_flag_d = 1'b0;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_n_q      <= '0;
            rsp_result_q <= '0;
            rsp_error_q  <= 1'b0;
`ifdef FACT_TIMEOUT_EN
            to_cnt_q       <= '0;
            timeout_flag_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_n_q      <= rsp_n_d;
            rsp_result_q <= rsp_result_d;
            rsp_error_q  <= rsp_error_d;
`ifdef FACT_TIMEOUT_EN
            to_cnt_q       <= to_cnt_d;
            timeout_flag_q <= timeout_flag_d;
`endif
        end
    end

    // The operand register drives the engine and stays put through WAIT.
    assign fact_in    = op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_n      = rsp_n_q;
    assign rsp_result = rsp_result_q;
    assign rsp_error  = rsp_error_q;
    assign busy       = (state_q != ST_IDLE) || !fifo_empty;
    assign dbg_state  = state_q;
`ifdef FACT_TIMEOUT_EN
    assign timeout_flag = timeout_flag_q;
`endif

endmodule

// File: tb/tb_fact_job_ctrl.sv
module tb_fact_job_ctrl;
    import fact_pkg::*;

    localparam int N_W   = 4;
    localparam int RES_W = 32;
    localparam int EW    = 2 + N_W + RES_W;   // {timeout, error, n, result}

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid, req_ready;
    logic [N_W-1:0]   req_n;
    logic             fact_go;
    logic [N_W-1:0]   fact_in;
    logic             fact_done, fact_error;
    logic [RES_W-1:0] fact_result;
    logic             rsp_valid, rsp_ready;
    logic [N_W-1:0]   rsp_n;
    logic [RES_W-1:0] rsp_result;
    logic             rsp_error, busy;
    state_e           dbg_state;
    logic             tflag;

    fact_job_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_n       (req_n),
        .fact_go     (fact_go),
        .fact_in     (fact_in),
        .fact_done   (fact_done),
        .fact_error  (fact_error),
        .fact_result (fact_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_n       (rsp_n),
        .rsp_result  (rsp_result),
        .rsp_error   (rsp_error),
        .busy        (busy),
        .dbg_state   (dbg_state)
`ifdef FACT_TIMEOUT_EN
        ,
        .timeout_flag (tflag)
`endif
    );

`ifndef FACT_TIMEOUT_EN
    assign tflag = 1'b0;
`endif

    always #5 clk = ~clk;

    int tot = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] fact32(input int n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 2; i <= n; i++) r = r * 32'(i);
        return r;
    endfunction

    // ---------------- reference model: expected response per accepted request
    bit expect_timeout = 1'b0;

    function automatic logic [EW-1:0] make_exp(input logic [N_W-1:0] n);
        logic err;
        if (expect_timeout) return {1'b1, 1'b1, n, 32'd0};
        err = (int'(n) > MAX_N);
        return {1'b0, err, n, err ? 32'd0 : fact32(int'(n))};
    endfunction

    logic [EW-1:0]  exp_q[$];
    logic [N_W-1:0] launch_q[$];
    logic [31:0]    rsp_log[$];
    logic [EW-1:0]  last_rsp;
    logic [EW-1:0]  held;
    bit             held_v = 1'b0;
    int             go_cnt = 0, acc_cnt = 0;
    int             last_go_cyc = 0, last_acc_cyc = 0;
    bit             go_pending = 1'b0;
    logic [N_W-1:0] go_n;

    // ---------------- compare process (samples on the falling edge)
    always @(negedge clk) begin
        logic [EW-1:0] cur;
        cur = {tflag, rsp_error, rsp_n, rsp_result};
        if (rst) begin
            exp_q.delete();
            launch_q.delete();
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                chk("rsp_hold_valid", 64'(rsp_valid), 64'd1);
                chk("rsp_hold_data", 64'(cur), 64'(held));
            end
            if (fact_go) begin
                go_cnt++;
                last_go_cyc = cyc;
                go_pending = 1'b1;
                go_n = fact_in;
                if (launch_q.size() == 0) chk("fact_go_extra", 64'd1, 64'd0);
                else chk("fact_in_order", 64'(fact_in), 64'(launch_q.pop_front()));
            end
            held_v = 1'b0;
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_spurious", 64'd1, 64'd0);
                end else if (rsp_ready) begin
                    chk("rsp_data", 64'(cur), 64'(exp_q.pop_front()));
                    last_rsp = cur;
                    rsp_log.push_back(rsp_result);
                end else begin
                    held_v = 1'b1;
                    held = cur;
                end
            end
            if (req_valid && req_ready) begin
                exp_q.push_back(make_exp(req_n));
                launch_q.push_back(req_n);
                acc_cnt++;
                last_acc_cyc = cyc;
            end
        end
    end

    // ---------------- engine model: Done after a delay, Error for n > MAX_N
    bit             eng_mute = 1'b0;
    int             eng_fixed = -1;
    bit             eng_busy = 1'b0;
    int             eng_cnt = 0;
    logic [N_W-1:0] eng_n;

    initial begin
        fact_done = 1'b0;
        fact_error = 1'b0;
        fact_result = '0;
        forever begin
            @(posedge clk);
            #1;
            fact_done = 1'b0;
            fact_error = 1'($urandom_range(0, 1));
            fact_result = $urandom;
            if (eng_busy) begin
                if (eng_cnt == 0) begin
                    fact_done = 1'b1;
                    fact_error = (int'(eng_n) > MAX_N);
                    fact_result = fact_error ? $urandom : fact32(int'(eng_n));
                    eng_busy = 1'b0;
                end else begin
                    eng_cnt--;
                end
            end
            if (go_pending) begin
                go_pending = 1'b0;
                if (!eng_mute) begin
                    eng_busy = 1'b1;
                    eng_n = go_n;
                    eng_cnt = (eng_fixed >= 0) ? eng_fixed : int'($urandom_range(0, 4));
                end
            end
        end
    end

    // ---------------- driver tasks (called just after a rising edge)
    bit rnd_ready = 1'b0;

    task automatic push(input logic [N_W-1:0] n);
        bit ok;
        req_valid = 1'b1;
        req_n = n;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = req_ready;
            @(posedge clk);
            #1;
            if (rnd_ready) rsp_ready = ($urandom_range(0, 2) != 0);
        end
        if (!ok) chk("push_timeout", 64'd0, 64'd1);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        bit done_ok;
        done_ok = 1'b0;
        for (int i = 0; i < 400 && !done_ok; i++) begin
            @(posedge clk);
            #1;
            done_ok = (exp_q.size() == 0) && !busy;
        end
        chk("drain_timeout", 64'(done_ok), 64'd1);
    endtask

    task automatic check_reset_vals();
        @(negedge clk);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_n", 64'(rsp_n), 64'd0);
        chk("rst_rsp_result", 64'(rsp_result), 64'd0);
        chk("rst_rsp_error", 64'(rsp_error), 64'd0);
        chk("rst_fact_go", 64'(fact_go), 64'd0);
        chk("rst_fact_in", 64'(fact_in), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0, go0;
        rst = 1'b1;
        req_valid = 1'b0;
        req_n = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_vals();

        // single job: go two cycles after acceptance, 3! = 6
        push(4'd3);
        drain();
        chk("single_latency", 64'(last_go_cyc - last_acc_cyc), 64'd2);
        chk("single_n", 64'(last_rsp[N_W+RES_W-1:RES_W]), 64'd3);
        chk("single_result", 64'(last_rsp[RES_W-1:0]), 64'd6);
        chk("single_error", 64'(last_rsp[EW-2]), 64'd0);

        // back-to-back
        rsp_log.delete();
        go0 = go_cnt;
        push(4'd5); push(4'd6); push(4'd7);
        drain();
        chk("b2b_count", 64'(rsp_log.size()), 64'd3);
        if (rsp_log.size() == 3) begin
            chk("b2b_0", 64'(rsp_log[0]), 64'd120);
            chk("b2b_1", 64'(rsp_log[1]), 64'd720);
            chk("b2b_2", 64'(rsp_log[2]), 64'd5040);
        end
        chk("b2b_go_count", 64'(go_cnt - go0), 64'd3);

        // max operand and overflow operand
        push(4'd12);
        drain();
        chk("n12_result", 64'(last_rsp[RES_W-1:0]), 64'd479001600);
        push(4'd13);
        drain();
        chk("n13_error", 64'(last_rsp[EW-2]), 64'd1);
        chk("n13_result", 64'(last_rsp[RES_W-1:0]), 64'd0);

        // backpressure: 1 in flight + DEPTH queued, then req_ready drops
        rsp_ready = 1'b0;
        rsp_log.delete();
        acc0 = acc_cnt;
        req_valid = 1'b1;
        for (int i = 0; i < 25; i++) begin
            req_n = 4'(acc_cnt - acc0 + 1);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        chk("full_accepted", 64'(acc_cnt - acc0), 64'd5);
        @(negedge clk);
        chk("full_req_ready", 64'(req_ready), 64'd0);
        chk("full_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        drain();
        chk("full_drain_count", 64'(rsp_log.size()), 64'd5);
        if (rsp_log.size() == 5) begin
            chk("full_d0", 64'(rsp_log[0]), 64'd1);
            chk("full_d4", 64'(rsp_log[4]), 64'd120);
        end
        push(4'd6); push(4'd7);
        drain();

        // reset with one job in WAIT and two queued; late Done must be ignored
        eng_fixed = 10;
        push(4'd5); push(4'd6); push(4'd7);
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        eng_fixed = -1;
        check_reset_vals();
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("late_done_ignored", 64'(rsp_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        push(4'd4);
        drain();
        chk("post_rst_result", 64'(last_rsp[RES_W-1:0]), 64'd24);

        // randomized traffic with random backpressure and engine delay
        rnd_ready = 1'b1;
        for (int j = 0; j < 40; j++) begin
            push(4'($urandom_range(0, 13)));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
                rsp_ready = ($urandom_range(0, 2) != 0);
            end
        end
        rnd_ready = 1'b0;
        rsp_ready = 1'b1;
        drain();

`ifdef FACT_TIMEOUT_EN
        // engine never answers: forced error response, then normal job
        eng_mute = 1'b1;
        expect_timeout = 1'b1;
        push(4'd2);
        expect_timeout = 1'b0;
        drain();
        chk("to_flag", 64'(last_rsp[EW-1]), 64'd1);
        chk("to_error", 64'(last_rsp[EW-2]), 64'd1);
        chk("to_result", 64'(last_rsp[RES_W-1:0]), 64'd0);
        eng_mute = 1'b0;
        push(4'd5);
        drain();
        chk("to_next_result", 64'(last_rsp[RES_W-1:0]), 64'd120);
        chk("to_next_flag", 64'(last_rsp[EW-1]), 64'd0);
`endif

        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
